host_seq: RTL
=============

HOST_SEQ -- requirements
Module: host_seq

Interface
REQ-001 Parameter LD_BASE, default 8'h00, first data_mem address written during load.
REQ-002 Parameter LD_N, default 8, number of bytes loaded (1..128).
REQ-003 Parameter RD_BASE, default 8'h40, first data_mem address read back after the core halts.
REQ-004 Parameter RD_N, default 4, number of bytes read back (1..128).
REQ-005 Parameter TMO, default 16'd4095, maximum core run cycles before abort.
REQ-006 Port list, one signal per line (name direction width meaning):
- clk  input  1  single clock, all state on rising edge
- reset  input  1  asynchronous, active-high
- start  input  1  begin one load/run/readback sequence
- ld_valid  input  1  load byte valid
- ld_data  input  8  load byte
- ld_ready  output  1  load byte accepted when ld_valid and ld_ready are both high
- mem_addr  output  8  data_mem address
- mem_wdata  output  8  data_mem write data
- mem_we  output  1  data_mem write strobe
- mem_re  output  1  data_mem read strobe
- mem_rdata  input  8  data_mem read data, valid the cycle after mem_re
- core_reset  output  1  reset driven to the CPU core
- core_done  input  1  CPU done (Halt and not reset)
- rd_valid  output  1  readback byte valid
- rd_data  output  8  readback byte
- rd_ready  input  1  readback byte consumed when rd_valid and rd_ready are both high
- busy  output  1  high in every state except IDLE and FIN
- timeout  output  1  sticky flag: the run phase was aborted
- cycles  output  16  core run-cycle count

Function
REQ-007 FSM states: IDLE, LOAD, CRST, RUN, RADDR, RWAIT, ROUT, FIN.
REQ-008 IDLE: core_reset=1; on start=1 go to LOAD, clear the byte index, timeout and cycles.
REQ-009 LOAD: ld_ready=1; each handshake drives mem_we=1, mem_addr=LD_BASE+idx, mem_wdata=ld_data, and increments idx in the same cycle (zero-latency write).
REQ-010 LOAD: once LD_N bytes have been accepted, go to CRST; ld_ready is 0 in every other state.
REQ-011 CRST: hold core_reset=1 for exactly 2 cycles, then go to RUN.
REQ-012 RUN: core_reset=0; cycles increments each cycle, saturating at 16'hFFFF.
REQ-013 RUN: core_done=1 goes to RADDR with idx cleared; core_done is ignored outside RUN.
REQ-014 RUN: when the run-cycle count reaches TMO without core_done, set timeout=1, assert core_reset=1, and go to RADDR; readback still runs.
REQ-015 From RADDR onward core_reset=1.
REQ-016 RADDR: drive mem_re=1, mem_addr=RD_BASE+idx for one cycle, then go to RWAIT.
REQ-017 RWAIT: capture mem_rdata into rd_data, set rd_valid=1, go to ROUT.
REQ-018 ROUT: hold rd_valid and rd_data stable until rd_ready=1.
REQ-019 On a ROUT handshake: increment idx; go to RADDR if idx<RD_N, otherwise go to FIN.
REQ-020 Readback throughput is at most one byte per 3 cycles.
REQ-021 FIN: busy=0, core_reset=1; start=1 restarts at LOAD; timeout and cycles hold until restarted.
REQ-022 start is ignored in all states except IDLE and FIN.
REQ-023 Address arithmetic is 8-bit and wraps modulo 256 (LD_BASE=8'hFE, LD_N=4 writes FE, FF, 00, 01).
REQ-024 mem_we and mem_re are never high in the same cycle.
REQ-025 Outside LOAD, RADDR and RWAIT, mem_addr=0 and mem_wdata=0.

Reset
REQ-026 Asserting reset forces, asynchronously and even mid-sequence: state IDLE, core_reset=1, mem_we=0, mem_re=0, ld_ready=0, rd_valid=0, rd_data=0, busy=0, timeout=0, cycles=0, idx=0.
REQ-027 A partially loaded or partially read sequence is abandoned and is not resumed after reset.

Configuration
REQ-028 Macro HOST_SEQ_CYCLE_COUNT_EN defined: cycles is a live 16-bit saturating counter per REQ-012.
REQ-029 Macro HOST_SEQ_CYCLE_COUNT_EN undefined: cycles is tied to 0.
REQ-030 Timeout detection in both configurations uses a separate internal counter of the same width, so timeout behaviour is identical either way.

Structure
REQ-031 Package host_seq_pkg holds the state enum type, the CRST_CYCLES=2 constant and the 16-bit count typedef.
REQ-032 A single sub-module host_seq_timer (saturating counter with clear, enable and terminal-compare) is instantiated for the run timer.

Verification
REQ-033 Nominal run: LD_N=4, bytes 11,22,33,44 -> mem writes at 00..03 in 4 consecutive cycles; core_reset high for 2 cycles; core_done after 20 cycles -> cycles=20, RD_N=4 words streamed from 40..43.
REQ-034 Load backpressure: ld_valid toggled every other cycle -> exactly LD_N writes, addresses sequential, no gaps or duplicates.
REQ-035 Timeout: TMO=50, core_done never asserted -> timeout=1 at run cycle 50, core_reset=1, readback still completes, FIN reached.
REQ-036 Readback backpressure: rd_ready held low 10 cycles -> rd_data stable throughout, no mem_re issued until the handshake.
REQ-037 Reset mid-RUN and mid-ROUT -> all outputs at reset values the same cycle; a new start then runs a full clean sequence.
REQ-038 Address wrap: LD_BASE=8'hFE, LD_N=4 -> writes to FE, FF, 00, 01; start pulsed during RUN has no effect.

Source files
------------

// File: rtl/host_seq_pkg.sv
// Shared types and constants for the host_seq load/run/readback sequencer.
package host_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CRST  = 3'd2,
    RUN   = 3'd3,
    RADDR = 3'd4,
    RWAIT = 3'd5,
    ROUT  = 3'd6,
    FIN   = 3'd7
  } state_t;

  localparam int CRST_CYCLES = 2;

  typedef logic [15:0] count_t;

  function automatic count_t sat_inc(input count_t v);
    if (v == 16'hFFFF) return v;
    else return v + 16'd1;
  endfunction

endpackage

// File: rtl/host_seq_timer.sv
// Saturating run timer with clear, enable and a terminal-count flag.
module host_seq_timer
  import host_seq_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   clr,
  input  logic   en,
  input  count_t term,
  output logic   hit
);

  count_t count_r;

  // Counter advances only while enabled and sticks at all-ones.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    count_r <= 16'h0000;
    else if (clr) count_r <= 16'h0000;
    else if (en)  count_r <= sat_inc(count_r);
    else          count_r <= count_r;
  end

  // Flag the cycle whose increment lands exactly on the terminal value.
  always_comb begin
    hit = 1'b0;
    if (en && (sat_inc(count_r) == term)) hit = 1'b1;
    else                                  hit = 1'b0;
  end

endmodule

// File: rtl/host_seq.sv
// Host sequencer: loads data_mem, runs the core under a timeout, streams results back.
// Define HOST_SEQ_CYCLE_COUNT_EN to make the cycles output a live run-cycle counter.
module host_seq
  import host_seq_pkg::*;
#(
  parameter logic [7:0] LD_BASE = 8'h00,
  parameter int         LD_N    = 8,
  parameter logic [7:0] RD_BASE = 8'h40,
  parameter int         RD_N    = 4,
  parameter count_t     TMO     = 16'd4095
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        ld_valid,
  input  logic [7:0]  ld_data,
  output logic        ld_ready,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        core_reset,
  input  logic        core_done,
  output logic        rd_valid,
  output logic [7:0]  rd_data,
  input  logic        rd_ready,
  output logic        busy,
  output logic        timeout,
  output logic [15:0] cycles
);

  localparam logic [7:0] LD_LAST   = 8'(LD_N - 1);
  localparam logic [7:0] RD_LAST   = 8'(RD_N - 1);
  localparam logic [7:0] CRST_LAST = 8'(CRST_CYCLES - 1);

  state_t     state_r, state_s;
  logic [7:0] idx_r, idx_s;
  logic [7:0] rd_data_r, rd_data_s;
  logic       timeout_r, timeout_s;
  logic       tmr_clr_s, tmr_en_s, tmr_hit_s;

  host_seq_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (tmr_clr_s),
    .en    (tmr_en_s),
    .term  (TMO),
    .hit   (tmr_hit_s)
  );

  // Sequencer state; idx is shared by load, core-reset hold and readback.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      idx_r     <= 8'h00;
      rd_data_r <= 8'h00;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      idx_r     <= idx_s;
      rd_data_r <= rd_data_s;
      timeout_r <= timeout_s;
    end
  end

  // Next-state and output decode; the load write is combinational on the handshake.
  always_comb begin
    state_s    = state_r;
    idx_s      = idx_r;
    rd_data_s  = rd_data_r;
    timeout_s  = timeout_r;
    tmr_clr_s  = 1'b0;
    tmr_en_s   = 1'b0;
    ld_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_re     = 1'b0;
    mem_addr   = 8'h00;
    mem_wdata  = 8'h00;
    core_reset = 1'b1;
    rd_valid   = 1'b0;
    busy       = 1'b1;
    case (state_r)
      IDLE, FIN: begin
        busy = 1'b0;
        if (start) begin
          state_s   = LOAD;
          idx_s     = 8'h00;
          timeout_s = 1'b0;
          tmr_clr_s = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_addr  = LD_BASE + idx_r;
          mem_wdata = ld_data;
          if (idx_r == LD_LAST) begin
            state_s = CRST;
            idx_s   = 8'h00;
          end else begin
            idx_s = idx_r + 8'd1;
          end
        end else begin
          idx_s = idx_r;
        end
      end
      CRST: begin
        if (idx_r == CRST_LAST) begin
          state_s = RUN;
          idx_s   = 8'h00;
        end else begin
          idx_s = idx_r + 8'd1;
        end
      end
      RUN: begin
        core_reset = 1'b0;
        tmr_en_s   = 1'b1;
        if (core_done) begin
          state_s = RADDR;
          idx_s   = 8'h00;
        end else if (tmr_hit_s) begin
          state_s   = RADDR;
          idx_s     = 8'h00;
          timeout_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      RADDR: begin
        mem_re   = 1'b1;
        mem_addr = RD_BASE + idx_r;
        state_s  = RWAIT;
      end
      RWAIT: begin
        mem_addr  = RD_BASE + idx_r;
        rd_data_s = mem_rdata;
        state_s   = ROUT;
      end
      ROUT: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          idx_s   = idx_r + 8'd1;
          state_s = (idx_r == RD_LAST) ? FIN : RADDR;
        end else begin
          state_s = ROUT;
        end
      end
      default: begin
        state_s = IDLE;
        idx_s   = 8'h00;
      end
    endcase
  end

  assign rd_data = rd_data_r;
  assign timeout = timeout_r;

`ifdef HOST_SEQ_CYCLE_COUNT_EN
  count_t cycles_r;

  // Visible run-cycle count, tracked independently of the timeout timer.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          cycles_r <= 16'h0000;
    else if (tmr_clr_s) cycles_r <= 16'h0000;
    else if (tmr_en_s)  cycles_r <= sat_inc(cycles_r);
    else                cycles_r <= cycles_r;
  end

  assign cycles = cycles_r;
`else
  assign cycles = 16'h0000;
`endif

endmodule
